// File: rtl/disp_pkg.sv
// -----------------------------------------------------------------------------
// disp_pkg
// Shared definitions for the 4-digit multiplexed 7-segment scan controller:
//   slot_state_t : per-slot phase (guard / on / off)
//   SEG_BLANK    : all segments and dp off (active-low)
//   ANODE_OFF    : all digit enables off (active-low)
//   HEX_SEG      : hex 0-F to {dp,g,f,e,d,c,b,a} patterns, dp off
// -----------------------------------------------------------------------------
package disp_pkg;

    typedef enum logic [1:0] {
        S_GUARD,
        S_ON,
        S_OFF
    } slot_state_t;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [3:0] ANODE_OFF = 4'hF;

    // Element n is the pattern for hex digit n (element 0 is the rightmost).
    localparam logic [15:0][7:0] HEX_SEG = {
        8'h8E, 8'h86, 8'hA1, 8'hC6,   // F E D C
        8'h83, 8'h88, 8'h90, 8'h80,   // B A 9 8
        8'hF8, 8'h82, 8'h92, 8'h99,   // 7 6 5 4
        8'hB0, 8'hA4, 8'hF9, 8'hC0    // 3 2 1 0
    };

endpackage

// File: rtl/hex7seg.sv
// -----------------------------------------------------------------------------
// hex7seg
// Combinational hex digit to 7-segment decoder, active-low.
//   hex : 4-bit value 0-F
//   seg : {g,f,e,d,c,b,a}, 0 = segment lit
// -----------------------------------------------------------------------------
module hex7seg
    import disp_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    always_comb begin
        seg = HEX_SEG[hex][6:0];
    end

endmodule

// File: rtl/disp_scan_ctrl.sv
// -----------------------------------------------------------------------------
// disp_scan_ctrl
// Scans four common-anode 7-segment digits (0,1,2,3,...), SCAN_DIV cycles per
// digit slot. Each slot starts with GUARD blank cycles (anti-ghosting), then
// ON_UNIT*(b+1) lit cycles, then blank for the rest of the slot.
// A valid/ready shadow register takes new values; they are committed only at
// the end of the digit-3 slot so a frame never mixes old and new data.
//   clk, reset          : clock, synchronous active-high reset
//   upd_valid/upd_ready : handshake for upd_data (4 hex digits) and upd_dp
//   bright              : brightness 0..7, sampled once per frame
//   lz_blank            : blank leading zeros on digits 3..1
//   anode               : active-low digit enables, bit i = digit i
//   catode              : active-low segments {dp,g,f,e,d,c,b,a}
//   frame_done          : pulse on the first cycle of each digit-0 slot
// After reset one blank slot runs before the first digit-0 slot, so the first
// frame_done comes SCAN_DIV cycles after reset is released.
// -----------------------------------------------------------------------------
module disp_scan_ctrl
    import disp_pkg::*;
#(
    parameter int SCAN_DIV = 10000,
    parameter int GUARD    = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        upd_valid,
    input  logic [15:0] upd_data,
    input  logic [3:0]  upd_dp,
    output logic        upd_ready,
    input  logic [2:0]  bright,
    input  logic        lz_blank,
    output logic [3:0]  anode,
    output logic [7:0]  catode,
    output logic        frame_done
);

    localparam int ON_UNIT = (SCAN_DIV - GUARD) / 8;
    localparam int CW      = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);

    logic [CW-1:0] cnt, cnt_nxt;
    logic [1:0]    digit, dig_nxt;
    logic          primed, primed_nxt;
    slot_state_t   state, state_nxt;
    logic [2:0]    b, b_eff;
    logic [15:0]   act_data, shd_data, data_nxt;
    logic [3:0]    act_dp, shd_dp, dp_nxt;
    logic          pending, pending_nxt;

    logic          last_cycle, frame_first, commit, xfer;
    int            on_end;
    logic [3:0]    cur_hex;
    logic          cur_dp;
    logic [3:0]    lead_zero;
    logic          blank;
    logic [6:0]    seg;

    hex7seg u_hex7seg (
        .hex (cur_hex),
        .seg (seg)
    );

    // Everything below computes the state of the coming cycle; the outputs are
    // registered from it so they line up exactly with the internal slot timing.
    // NOTE: every signal gets a default at the top of always_comb so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        last_cycle  = (cnt == CNT_MAX);
        frame_first = primed && (digit == 2'd0) && (cnt == '0);
        b_eff       = frame_first ? bright : b;
        commit      = last_cycle && (digit == 2'd3) && pending;
        xfer        = upd_valid && upd_ready;

        cnt_nxt     = last_cycle ? '0 : cnt + 1'b1;
        primed_nxt  = primed | last_cycle;
        // The blank post-reset slot does not advance the digit index.
        dig_nxt     = (last_cycle && primed) ? digit + 2'd1 : digit;
        data_nxt    = commit ? shd_data : act_data;
        dp_nxt      = commit ? shd_dp   : act_dp;
        pending_nxt = commit ? 1'b0 : (xfer ? 1'b1 : pending);

        on_end      = GUARD + ON_UNIT * (int'(b_eff) + 1);

        state_nxt = state;
        case (state)
            S_GUARD: if (primed_nxt && int'(cnt_nxt) == GUARD) state_nxt = S_ON;
            // With b=7 the lit window reaches the slot end, so OFF is skipped.
            S_ON: begin
                if (cnt_nxt == '0)                  state_nxt = S_GUARD;
                else if (int'(cnt_nxt) == on_end)   state_nxt = S_OFF;
            end
            S_OFF:   if (cnt_nxt == '0) state_nxt = S_GUARD;
            default: state_nxt = S_GUARD;
        endcase

        cur_hex = data_nxt[{dig_nxt, 2'b00} +: 4];
        cur_dp  = dp_nxt[dig_nxt];

        // lead_zero[k]: digits k..3 are all zero; digit 0 is never blanked.
        lead_zero[3] = (data_nxt[15:12] == 4'h0);
        lead_zero[2] = lead_zero[3] && (data_nxt[11:8] == 4'h0);
        lead_zero[1] = lead_zero[2] && (data_nxt[7:4]  == 4'h0);
        lead_zero[0] = 1'b0;
        blank        = lz_blank && lead_zero[dig_nxt];
    end

    // NOTE: reset is sampled on the clock edge only, and all state uses
    // non-blocking assignments so every register updates from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            digit      <= 2'd0;
            primed     <= 1'b0;
            state      <= S_GUARD;
            b          <= 3'd0;
            act_data   <= 16'h0000;
            act_dp     <= 4'h0;
            shd_data   <= 16'h0000;
            shd_dp     <= 4'h0;
            pending    <= 1'b0;
            anode      <= ANODE_OFF;
            catode     <= SEG_BLANK;
            frame_done <= 1'b0;
            upd_ready  <= 1'b1;
        end else begin
            cnt      <= cnt_nxt;
            digit    <= dig_nxt;
            primed   <= primed_nxt;
            state    <= state_nxt;
            b        <= b_eff;
            act_data <= data_nxt;
            act_dp   <= dp_nxt;
            pending  <= pending_nxt;
            if (xfer) begin
                shd_data <= upd_data;
                shd_dp   <= upd_dp;
            end

            if (state_nxt == S_ON) begin
                anode  <= ~(4'b0001 << dig_nxt);
                catode <= {~cur_dp, blank ? 7'h7F : seg};
            end else begin
                anode  <= ANODE_OFF;
                catode <= SEG_BLANK;
            end
            frame_done <= primed_nxt && (cnt_nxt == '0) && (dig_nxt == 2'd0);
            upd_ready  <= ~pending_nxt;
        end
    end

endmodule

// File: doc/disp_scan_ctrl.md
DISP_SCAN_CTRL -- requirements
Module: disp_scan_ctrl

Interface
REQ-001 Parameter SCAN_DIV, default 10000, clk cycles per digit slot; SHALL satisfy SCAN_DIV >= GUARD+8.
REQ-002 Parameter GUARD, default 16, anode-off cycles at the start of each slot (anti-ghosting); SHALL be >= 1.
REQ-003 Derived constant ON_UNIT = (SCAN_DIV-GUARD)/8 (integer division), on-time per brightness step.
REQ-004 clk  in  1  the single clock; all logic SHALL be synchronous to it, with no derived clocks.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 upd_valid  in  1  new display value offered.
REQ-007 upd_data  in  16  hex value; digit i = upd_data[4i+3:4i].
REQ-008 upd_dp  in  4  decimal-point enables, bit i for digit i.
REQ-009 upd_ready  out  1  shadow register free; transfer occurs on the cycle where upd_valid && upd_ready.
REQ-010 bright  in  3  brightness, 0 (dimmest) to 7 (full).
REQ-011 lz_blank  in  1  enable leading-zero blanking.
REQ-012 anode  out  4  active-low digit enables, bit i = digit i (digit 0 rightmost).
REQ-013 catode  out  8  active-low segments {dp,g,f,e,d,c,b,a}.
REQ-014 frame_done  out  1  one-cycle pulse marking the first cycle of each digit-0 slot.

Function
REQ-015 Digits SHALL be scanned in the order 0,1,2,3,0,...; each slot lasts exactly SCAN_DIV cycles, with slot counter cnt = 0..SCAN_DIV-1.
REQ-016 Per-slot FSM states: GUARD (cnt < GUARD), ON (GUARD <= cnt < GUARD+ON_UNIT*(b+1)), OFF (remaining cycles); OFF SHALL be skipped when its length is 0.
REQ-017 In GUARD and OFF, anode SHALL be 4'b1111 and catode SHALL be 8'hFF; in ON, exactly one anode bit (the current digit) SHALL be low.
REQ-018 b is bright sampled at the first cycle of each digit-0 slot and SHALL be held for the whole frame.
REQ-019 All outputs SHALL be registered; the observed slot timing, measured from frame_done, SHALL match REQ-015 to REQ-017 exactly.
REQ-020 Segment decode SHALL be standard hex 0-F, e.g. 0 = 8'hC0, 1 = 8'hF9, 8 = 8'h80, A = 8'h88, F = 8'h8E (dp bit off).
REQ-021 With lz_blank=1, digit k (k = 3,2,1) SHALL be blanked (segments a-g off) when the active digits k..3 are all zero; digit 0 SHALL never be blanked.
REQ-022 The dp of digit i SHALL be lit (catode[7]=0) during ON when active_dp[i]=1, even if digit i is blanked.
REQ-023 An accepted transfer SHALL load the shadow registers (data, dp), set pending, and drive upd_ready low on the next cycle.
REQ-024 Commit: on the last cycle of the digit-3 slot, if pending is set, active <= shadow and pending clears; upd_ready SHALL return high on the next cycle.
REQ-025 A new value SHALL first be displayed in the digit-0 slot immediately following its commit; a frame SHALL never mix old and new values (no tearing).
REQ-026 A transfer and a commit cannot occur in the same cycle, because upd_ready=0 while pending; the next offer SHALL wait for upd_ready.
REQ-027 frame_done SHALL be high for exactly 1 cycle every 4*SCAN_DIV cycles.

Reset
REQ-028 While reset is high, and on the following cycle: anode=4'hF, catode=8'hFF, frame_done=0, upd_ready=1.
REQ-029 Reset SHALL clear the digit index to 0, cnt to 0, the FSM to GUARD, active and shadow data/dp to 0, pending to 0, and b to 0.
REQ-030 Reset mid-frame or mid-handshake SHALL discard the pending shadow value; the first frame_done SHALL occur SCAN_DIV cycles after reset deassertion.

Structure
REQ-031 Package disp_pkg SHALL hold the FSM state enum (GUARD/ON/OFF), SEG_BLANK = 8'hFF, ANODE_OFF = 4'hF and the hex segment table constants.
REQ-032 Sub-module hex7seg (combinational 4-bit to 7-segment, active-low) SHALL be instantiated once, on the muxed current digit.

Verification (SCAN_DIV=18, GUARD=2, ON_UNIT=2)
REQ-033 Reset, then offer 16'h1A80 with dp=0, bright=7 -> after commit, the digit-0 slot shows catode 8'hC0 for cnt 2..17 with anode 4'b1110, and the digit-3 slot shows 8'hF9 with anode 4'b0111.
REQ-034 bright=0 -> anode is low for exactly 2 cycles per slot (cnt 2..3) and high for the remaining 16.
REQ-035 lz_blank=1, data 16'h0005 -> digits 3..1 show 8'hFF and digit 0 shows 8'h92; with data 16'h0000, digit 0 shows 8'hC0.
REQ-036 Offer 16'h1111 during a digit-1 slot -> upd_ready drops next cycle; the current frame still shows the old value; the next frame shows 8'hF9 on all digits; upd_ready rises 1 cycle after the last digit-3 cycle.
REQ-037 Assert reset for 1 cycle mid-slot while pending -> outputs go to 4'hF/8'hFF, upd_ready=1, the old value is lost (display 0), and frame_done first pulses 18 cycles after reset deasserts.
REQ-038 Hold upd_valid continuously with changing data -> exactly one transfer per frame, and every displayed frame is internally consistent.
